xlr8_hall_capture: RTL and testbench

XLR8_HALL_CAPTURE -- requirements
Module: xlr8_hall_capture

---
 rtl/xlr8_hall_pkg.sv | 56 +++++
 rtl/xlr8_hall_debounce.sv | 62 ++++++
 rtl/xlr8_hall_capture.sv | 219 +++++++++++++++++++++
 tb/tb_xlr8_hall_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xlr8_hall_pkg.sv
// Shared definitions for the Hall-sensor capture block: step type, decode
// table, commutation-step helpers and CTRL/STAT bit positions.
package xlr8_hall_pkg;

  typedef logic [2:0] hall_step_t;

  typedef struct packed {
    logic       valid;
    hall_step_t step;
  } hall_dec_t;

  // CTRL register bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  // STAT register bit positions
  localparam int STAT_STEP_LSB = 0;
  localparam int STAT_STEP_MSB = 2;
  localparam int STAT_DIR      = 3;
  localparam int STAT_VALID    = 4;
  localparam int STAT_NEW      = 5;
  localparam int STAT_FAULT    = 6;
  localparam int STAT_OVF      = 7;

  localparam hall_step_t STEP_MAX = 3'd5;

  // Map a {fb3,fb2,fb1} code to a commutation step; 000 and 111 are illegal.
  function automatic hall_dec_t hall_decode(input logic [2:0] code);
    hall_dec_t dec;
    dec.valid = 1'b1;
    case (code)
      3'b001:  dec.step = 3'd0;
      3'b011:  dec.step = 3'd1;
      3'b010:  dec.step = 3'd2;
      3'b110:  dec.step = 3'd3;
      3'b100:  dec.step = 3'd4;
      3'b101:  dec.step = 3'd5;
      default: begin
        dec.valid = 1'b0;
        dec.step  = 3'd0;
      end
    endcase
    return dec;
  endfunction

  // Next step in the forward direction, wrapping 5 -> 0.
  function automatic hall_step_t step_next(input hall_step_t s);
    return (s >= STEP_MAX) ? 3'd0 : (s + 3'd1);
  endfunction

  // Next step in the reverse direction, wrapping 0 -> 5.
  function automatic hall_step_t step_prev(input hall_step_t s);
    return (s == 3'd0) ? STEP_MAX : (s - 3'd1);
  endfunction

endpackage

// File: rtl/xlr8_hall_debounce.sv
// Hall code filter: a new code is accepted only after DEBOUNCE_CYCLES
// consecutive identical samples that differ from the accepted code. Any
// differing sample restarts the count with that sample as the new candidate.
module xlr8_hall_debounce
  import xlr8_hall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] code_in,
  output logic [2:0] code_out
);

  localparam logic [7:0] LEN = 8'(DEBOUNCE_CYCLES);

  logic [2:0] code_q, code_d;
  logic [2:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc_s;

  // Candidate tracking and acceptance decision.
  always_comb begin
    code_d    = code_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    cnt_inc_s = 8'd0;
    if (code_in == code_q) begin
      cand_d = code_q;
      cnt_d  = 8'd0;
    end else begin
      if ((cnt_q != 8'd0) && (code_in == cand_q)) begin
        cnt_inc_s = cnt_q + 8'd1;
      end else begin
        cnt_inc_s = 8'd1;
      end
      cand_d = code_in;
      if (cnt_inc_s >= LEN) begin
        code_d = code_in;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end
  end

  // Filter state; reset drops any pending candidate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_q <= 3'b000;
      cand_q <= 3'b000;
      cnt_q  <= 8'd0;
    end else begin
      code_q <= code_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign code_out = code_q;

endmodule

// File: rtl/xlr8_hall_capture.sv
// Hall-sensor commutation capture with period measurement and a small
// data-memory register interface (CTRL, STAT, PERL, PERH).
// Optional input filter enabled by defining XLR8_HALL_DEBOUNCE_EN.
module xlr8_hall_capture
  import xlr8_hall_pkg::*;
#(
  parameter int HALL_CTRL_ADDR  = 0,
  parameter int HALL_STAT_ADDR  = 0,
  parameter int HALL_PERL_ADDR  = 0,
  parameter int HALL_PERH_ADDR  = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clken,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic       dm_sel,
  input  logic       feedback_1,
  input  logic       feedback_2,
  input  logic       feedback_3,
  output logic [2:0] hall_step,
  output logic       hall_valid,
  output logic       step_strobe
);

  localparam logic [7:0] CTRL_A = 8'(HALL_CTRL_ADDR);
  localparam logic [7:0] STAT_A = 8'(HALL_STAT_ADDR);
  localparam logic [7:0] PERL_A = 8'(HALL_PERL_ADDR);
  localparam logic [7:0] PERH_A = 8'(HALL_PERH_ADDR);

  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]  acc_code_s;
  logic [2:0]  last_code_q, last_code_d;
  hall_step_t  hall_step_q, hall_step_d;
  logic        hall_valid_q, hall_valid_d;
  logic        step_strobe_q, step_strobe_d;
  logic        en_q, en_d, dir_q, dir_d, new_q, new_d;
  logic        fault_q, fault_d, ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d, period_q, period_d;
  logic [7:0]  shadow_q, shadow_d;
  hall_dec_t   dec_s;
  logic        change_s, step_evt_s, fwd_s, bwd_s, fault_set_s, ovf_set_s;
  logic        rd_s, hit_ctrl_s, hit_stat_s, hit_perl_s, hit_perh_s;
  logic        ctrl_wr_s, clr_s;
  logic [7:0]  stat_s, ctrl_rd_s;
  logic [5:0]  dbus_in_unused;

  assign dbus_in_unused = dbus_in[7:2];

`ifdef XLR8_HALL_DEBOUNCE_EN
  xlr8_hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .code_in (sync2_q),
    .code_out(acc_code_s)
  );
`else
  localparam int debounce_cycles_unused = DEBOUNCE_CYCLES;
  assign acc_code_s = sync2_q;
`endif

  assign dec_s = hall_decode(acc_code_s);

  // Bus decode, register read mux and side-effect qualifiers.
  always_comb begin
    rd_s       = dm_sel & ramre;
    hit_ctrl_s = (ramadr == CTRL_A);
    hit_stat_s = (ramadr == STAT_A);
    hit_perl_s = (ramadr == PERL_A);
    hit_perh_s = (ramadr == PERH_A);
    ctrl_wr_s  = dm_sel & ramwe & clken & hit_ctrl_s;
    clr_s      = ctrl_wr_s & dbus_in[CTRL_CLR];
    ctrl_rd_s  = 8'h00;
    ctrl_rd_s[CTRL_EN] = en_q;
    stat_s     = 8'h00;
    stat_s[STAT_STEP_MSB:STAT_STEP_LSB] = hall_step_q;
    stat_s[STAT_DIR]   = dir_q;
    stat_s[STAT_VALID] = hall_valid_q;
    stat_s[STAT_NEW]   = new_q;
    stat_s[STAT_FAULT] = fault_q;
    stat_s[STAT_OVF]   = ovf_q;
    io_out_en  = rd_s & (hit_ctrl_s | hit_stat_s | hit_perl_s | hit_perh_s);
    dbus_out   = ({8{rd_s & hit_ctrl_s}} & ctrl_rd_s)
               | ({8{rd_s & hit_stat_s}} & stat_s)
               | ({8{rd_s & hit_perl_s}} & period_q[7:0])
               | ({8{rd_s & hit_perh_s}} & shadow_q);
  end

  // Step tracking, direction/fault classification, period counter and flags.
  always_comb begin
    sync1_d     = {feedback_3, feedback_2, feedback_1};
    sync2_d     = sync1_q;
    last_code_d = acc_code_s;
    change_s    = (acc_code_s != last_code_q);
    step_evt_s  = en_q & change_s & dec_s.valid & (dec_s.step != hall_step_q);
    fwd_s       = (dec_s.step == step_next(hall_step_q));
    bwd_s       = (dec_s.step == step_prev(hall_step_q));
    fault_set_s = (en_q & change_s & ~dec_s.valid) | (step_evt_s & ~fwd_s & ~bwd_s);
    ovf_set_s   = en_q & (cnt_q == 16'hFFFF);
    step_strobe_d = step_evt_s;

    if (dec_s.valid) begin
      hall_step_d  = dec_s.step;
      hall_valid_d = 1'b1;
    end else begin
      hall_step_d  = hall_step_q;
      hall_valid_d = 1'b0;
    end

    if (ctrl_wr_s) begin
      en_d = dbus_in[CTRL_EN];
    end else begin
      en_d = en_q;
    end

    if (!en_q) begin
      cnt_d = 16'h0000;
    end else if (step_evt_s) begin
      cnt_d = 16'h0001;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'h0001;
    end

    if (step_evt_s) begin
      period_d = cnt_q;
    end else begin
      period_d = period_q;
    end

    if (step_evt_s && fwd_s) begin
      dir_d = 1'b1;
    end else if (step_evt_s && bwd_s) begin
      dir_d = 1'b0;
    end else begin
      dir_d = dir_q;
    end

    // A capture in the same cycle as a STAT read keeps the flag set.
    if (step_evt_s) begin
      new_d = 1'b1;
    end else if (rd_s && hit_stat_s) begin
      new_d = 1'b0;
    end else begin
      new_d = new_q;
    end

    if (fault_set_s) begin
      fault_d = 1'b1;
    end else if (clr_s) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end

    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // High byte is frozen on a PERL read so a PERL/PERH pair is coherent.
    if (rd_s && hit_perl_s) begin
      shadow_d = period_q[15:8];
    end else begin
      shadow_d = shadow_q;
    end
  end

  // All state registers, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      last_code_q   <= 3'b000;
      hall_step_q   <= 3'd0;
      hall_valid_q  <= 1'b0;
      step_strobe_q <= 1'b0;
      en_q          <= 1'b0;
      dir_q         <= 1'b0;
      new_q         <= 1'b0;
      fault_q       <= 1'b0;
      ovf_q         <= 1'b0;
      cnt_q         <= 16'h0000;
      period_q      <= 16'h0000;
      shadow_q      <= 8'h00;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      last_code_q   <= last_code_d;
      hall_step_q   <= hall_step_d;
      hall_valid_q  <= hall_valid_d;
      step_strobe_q <= step_strobe_d;
      en_q          <= en_d;
      dir_q         <= dir_d;
      new_q         <= new_d;
      fault_q       <= fault_d;
      ovf_q         <= ovf_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      shadow_q      <= shadow_d;
    end
  end

  assign hall_step   = hall_step_q;
  assign hall_valid  = hall_valid_q;
  assign step_strobe = step_strobe_q;

endmodule

// File: tb/tb_xlr8_hall_capture.sv
// Directed bench for xlr8_hall_capture: table-driven commutation vectors
// plus hand-written sequences for glitch, period capture, overflow,
// enable gating and asynchronous reset.
module tb_xlr8_hall_capture;

  localparam int DB = 4;
  localparam logic [7:0] A_CTRL = 8'h40;
  localparam logic [7:0] A_STAT = 8'h41;
  localparam logic [7:0] A_PERL = 8'h42;
  localparam logic [7:0] A_PERH = 8'h43;
  localparam logic [7:0] A_NONE = 8'h55;
  // Cycles from the first clock edge that samples a new input code to the
  // edge that raises step_strobe.
`ifdef XLR8_HALL_DEBOUNCE_EN
  localparam int LAT_EXP = 2 + DB;
`else
  localparam int LAT_EXP = 2;
`endif

  logic       clk, rstn, clken, ramre, ramwe, dm_sel;
  logic       feedback_1, feedback_2, feedback_3;
  logic [7:0] dbus_in, dbus_out, ramadr;
  logic       io_out_en, hall_valid, step_strobe;
  logic [2:0] hall_step;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  xlr8_hall_capture #(
    .HALL_CTRL_ADDR (32'h40),
    .HALL_STAT_ADDR (32'h41),
    .HALL_PERL_ADDR (32'h42),
    .HALL_PERH_ADDR (32'h43),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clken      (clken),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .io_out_en  (io_out_en),
    .ramadr     (ramadr),
    .ramre      (ramre),
    .ramwe      (ramwe),
    .dm_sel     (dm_sel),
    .feedback_1 (feedback_1),
    .feedback_2 (feedback_2),
    .feedback_3 (feedback_3),
    .hall_step  (hall_step),
    .hall_valid (hall_valid),
    .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to space input edges exactly.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] code;
    logic       strobe;
    logic [2:0] step;
    logic       valid;
    logic       dir;
    logic       fault;
    logic       clr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_code(input logic [2:0] c);
    {feedback_3, feedback_2, feedback_1} = c;
  endtask

  task automatic drive_at(input int k, input logic [2:0] c);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
    set_code(c);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    dm_sel = 1'b1; ramwe = 1'b1; clken = 1'b1; ramadr = a; dbus_in = d;
    @(posedge clk);
    #1;
    dm_sel = 1'b0; ramwe = 1'b0; clken = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic e);
    dm_sel = 1'b1; ramre = 1'b1; ramadr = a;
    #2;
    d = dbus_out;
    e = io_out_en;
    @(posedge clk);
    #1;
    dm_sel = 1'b0; ramre = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp, input logic exp_en);
    logic [7:0] d;
    logic e;
    bus_read(a, d, e);
    check({name, ".data"}, {24'd0, d}, {24'd0, exp});
    check({name, ".en"}, {31'd0, e}, {31'd0, exp_en});
  endtask

  // Counts posedges until step_strobe is seen; -1 if it never comes.
  task automatic wait_strobe(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (step_strobe) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_no_strobe(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step_strobe) seen = 1'b1;
    end
  endtask

  task automatic step_chk(input string name, input logic [2:0] c);
    int lat;
    set_code(c);
    wait_strobe(lat);
    check({name, ".lat"}, lat - 1, LAT_EXP);
  endtask

  initial begin
    logic [7:0] d;
    logic e, seen;
    int lat, c0;

    vecs[0]  = '{3'b011, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b110, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b101, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b101, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{3'b100, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'b010, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1};

    rstn = 1'b0; clken = 1'b0; ramre = 1'b0; ramwe = 1'b0; dm_sel = 1'b0;
    dbus_in = 8'h00; ramadr = 8'h00;
    set_code(3'b001);
    repeat (3) @(posedge clk);
    #1;
    check("rst.hall_step", {29'd0, hall_step}, 32'd0);
    check("rst.hall_valid", {31'd0, hall_valid}, 32'd0);
    check("rst.step_strobe", {31'd0, step_strobe}, 32'd0);
    check("rst.dbus_out", {24'd0, dbus_out}, 32'd0);
    check("rst.io_out_en", {31'd0, io_out_en}, 32'd0);
    rstn = 1'b1;
    wait_no_strobe(LAT_EXP + 4, seen);
    check("init.no_strobe", {31'd0, seen}, 32'd0);
    check("init.hall_valid", {31'd0, hall_valid}, 32'd1);
    check("init.hall_step", {29'd0, hall_step}, 32'd0);
    rd_chk("init.ctrl", A_CTRL, 8'h00, 1'b1);
    rd_chk("init.stat", A_STAT, 8'h10, 1'b1);
    rd_chk("init.perl", A_PERL, 8'h00, 1'b1);
    rd_chk("init.perh", A_PERH, 8'h00, 1'b1);
    rd_chk("unmapped", A_NONE, 8'h00, 1'b0);
    bus_write(A_CTRL, 8'h01);
    rd_chk("en.ctrl", A_CTRL, 8'h01, 1'b1);

    // Commutation table: strobe latency, outputs and STAT after each code.
    for (int i = 0; i < 13; i++) begin
      set_code(vecs[i].code);
      if (vecs[i].strobe) begin
        wait_strobe(lat);
        check($sformatf("v%0d.lat", i), lat - 1, LAT_EXP);
        @(posedge clk);
        #1;
        check($sformatf("v%0d.width", i), {31'd0, step_strobe}, 32'd0);
      end else begin
        wait_no_strobe(LAT_EXP + 6, seen);
        check($sformatf("v%0d.no_strobe", i), {31'd0, seen}, 32'd0);
      end
      check($sformatf("v%0d.hall_step", i), {29'd0, hall_step}, {29'd0, vecs[i].step});
      check($sformatf("v%0d.hall_valid", i), {31'd0, hall_valid}, {31'd0, vecs[i].valid});
      rd_chk($sformatf("v%0d.stat", i), A_STAT,
             {1'b0, vecs[i].fault, vecs[i].strobe, vecs[i].valid, vecs[i].dir, vecs[i].step}, 1'b1);
      if (vecs[i].clr) begin
        bus_write(A_CTRL, 8'h03);
        bus_read(A_STAT, d, e);
        check($sformatf("v%0d.fault_clr", i), {31'd0, d[6]}, 32'd0);
        rd_chk($sformatf("v%0d.ctrl", i), A_CTRL, 8'h01, 1'b1);
      end
    end

    // Short glitch from step 2 to code 110 and back.
    set_code(3'b110);
    repeat (2) @(posedge clk);
    #1;
    set_code(3'b010);
    wait_no_strobe(LAT_EXP + 8, seen);
`ifdef XLR8_HALL_DEBOUNCE_EN
    check("glitch.no_strobe", {31'd0, seen}, 32'd0);
`else
    check("glitch.passthru", {31'd0, seen}, 32'd1);
`endif
    check("glitch.hall_step", {29'd0, hall_step}, 32'd2);

    // Period capture 0x01FF then 0x0300 with PERH shadow coherence.
    c0 = cyc;
    set_code(3'b110);
    drive_at(c0 + 511, 3'b100);
    wait_strobe(lat);
    check("per1.lat", lat - 1, LAT_EXP);
    rd_chk("per1.perl", A_PERL, 8'hFF, 1'b1);
    drive_at(c0 + 511 + 768, 3'b101);
    wait_strobe(lat);
    check("per2.lat", lat - 1, LAT_EXP);
    rd_chk("per2.perh_shadow", A_PERH, 8'h01, 1'b1);
    rd_chk("per2.perl", A_PERL, 8'h00, 1'b1);
    rd_chk("per2.perh", A_PERH, 8'h03, 1'b1);

    // Long hold saturates the counter and sets ovf.
    repeat (70000) @(posedge clk);
    #1;
    bus_read(A_STAT, d, e);
    check("ovf.set", {31'd0, d[7]}, 32'd1);
    c0 = cyc;
    step_chk("ovf.step", 3'b001);
    rd_chk("ovf.perl", A_PERL, 8'hFF, 1'b1);
    rd_chk("ovf.perh", A_PERH, 8'hFF, 1'b1);
    drive_at(c0 + 100, 3'b011);
    wait_strobe(lat);
    check("restart.lat", lat - 1, LAT_EXP);
    rd_chk("restart.perl", A_PERL, 8'h64, 1'b1);
    rd_chk("restart.perh", A_PERH, 8'h00, 1'b1);
    bus_read(A_STAT, d, e);
    check("ovf.sticky", {31'd0, d[7]}, 32'd1);
    bus_write(A_CTRL, 8'h03);
    bus_read(A_STAT, d, e);
    check("ovf.clr", {31'd0, d[7]}, 32'd0);
    rd_chk("ovf.ctrl", A_CTRL, 8'h01, 1'b1);

    // Disabled: decode stays live, no strobe, period holds.
    bus_write(A_CTRL, 8'h00);
    rd_chk("dis.ctrl", A_CTRL, 8'h00, 1'b1);
    set_code(3'b010);
    wait_no_strobe(LAT_EXP + 6, seen);
    check("dis.no_strobe", {31'd0, seen}, 32'd0);
    check("dis.hall_step", {29'd0, hall_step}, 32'd2);
    rd_chk("dis.perl", A_PERL, 8'h64, 1'b1);

    // Asynchronous reset in the middle of an input change.
    bus_write(A_CTRL, 8'h01);
    set_code(3'b110);
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("arst.hall_step", {29'd0, hall_step}, 32'd0);
    check("arst.hall_valid", {31'd0, hall_valid}, 32'd0);
    check("arst.step_strobe", {31'd0, step_strobe}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (LAT_EXP) @(posedge clk);
    #1;
    check("arst.step_pending", {29'd0, hall_step}, 32'd0);
    @(posedge clk);
    #1;
    check("arst.step_after", {29'd0, hall_step}, 32'd3);
    check("arst.no_strobe", {31'd0, step_strobe}, 32'd0);
    rd_chk("arst.ctrl", A_CTRL, 8'h00, 1'b1);
    rd_chk("arst.stat", A_STAT, 8'h13, 1'b1);
    rd_chk("arst.perl", A_PERL, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
